if_stage: RTL and testbench

- Instruction-fetch stage.
- Owns the program counter and drives the combinational instruction memory address each cycle.
- Captures the returned instruction together with its PC into the IF/ID pipeline register consumed by the decoder.
- Handles stall from hazard detection, branch/jump redirect from EX, end-of-program halt, and a fetched-instruction counter.

---
 rtl/if_stage.sv | 100 ++++++++++
 tb/tb_if_stage.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// rtl/if_stage.sv - instruction-fetch stage: PC, IMEM addressing, IF/ID register, halt and fetch count
module if_stage #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          IMEM_WORDS = 32,
    parameter logic [31:0] NOP_INSTR  = 32'h0000_0013
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        stall_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_target_i,
    output logic [31:0] imem_addr_o,
    input  logic [31:0] imem_instr_i,
    output logic [31:0] pc_o,
    output logic [31:0] ifid_pc_o,
    output logic [31:0] ifid_pc4_o,
    output logic [31:0] ifid_instr_o,
    output logic        ifid_valid_o,
    output logic        halted_o,
    output logic        align_err_o,
    output logic [31:0] fetch_cnt_o
);

    localparam logic [31:0] IMEM_BYTES = 32'(IMEM_WORDS * 4);

    logic [31:0] pc_q, pc_d;
    logic [31:0] ifid_pc_q, ifid_pc_d;
    logic [31:0] ifid_pc4_q, ifid_pc4_d;
    logic [31:0] ifid_instr_q, ifid_instr_d;
    logic        ifid_valid_q, ifid_valid_d;
    logic        align_err_q, align_err_d;
    logic [31:0] fetch_cnt_q, fetch_cnt_d;
    logic [31:0] pc_plus4;
    logic        halted;

    assign pc_plus4 = pc_q + 32'd4;
    assign halted   = (pc_q >= IMEM_BYTES);

    // Redirect beats stall beats halt; a halted PC never trusts imem_instr_i.
    always_comb begin
        pc_d         = pc_q;
        ifid_pc_d    = ifid_pc_q;
        ifid_pc4_d   = ifid_pc4_q;
        ifid_instr_d = ifid_instr_q;
        ifid_valid_d = ifid_valid_q;
        align_err_d  = align_err_q;
        fetch_cnt_d  = fetch_cnt_q;
        if (redirect_i) begin
            pc_d         = {redirect_target_i[31:2], 2'b00};
            ifid_instr_d = NOP_INSTR;
            ifid_valid_d = 1'b0;
            if (redirect_target_i[1:0] != 2'b00) begin
                align_err_d = 1'b1;
            end
        end else if (stall_i) begin
            pc_d = pc_q;
        end else if (halted) begin
            ifid_instr_d = NOP_INSTR;
            ifid_valid_d = 1'b0;
        end else begin
            pc_d         = pc_plus4;
            ifid_pc_d    = pc_q;
            ifid_pc4_d   = pc_plus4;
            ifid_instr_d = imem_instr_i;
            ifid_valid_d = 1'b1;
            fetch_cnt_d  = fetch_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pc_q         <= RESET_PC;
            ifid_pc_q    <= 32'd0;
            ifid_pc4_q   <= 32'd0;
            ifid_instr_q <= NOP_INSTR;
            ifid_valid_q <= 1'b0;
            align_err_q  <= 1'b0;
            fetch_cnt_q  <= 32'd0;
        end else begin
            pc_q         <= pc_d;
            ifid_pc_q    <= ifid_pc_d;
            ifid_pc4_q   <= ifid_pc4_d;
            ifid_instr_q <= ifid_instr_d;
            ifid_valid_q <= ifid_valid_d;
            align_err_q  <= align_err_d;
            fetch_cnt_q  <= fetch_cnt_d;
        end
    end

    assign imem_addr_o  = pc_q;
    assign pc_o         = pc_q;
    assign ifid_pc_o    = ifid_pc_q;
    assign ifid_pc4_o   = ifid_pc4_q;
    assign ifid_instr_o = ifid_instr_q;
    assign ifid_valid_o = ifid_valid_q;
    assign halted_o     = halted;
    assign align_err_o  = align_err_q;
    assign fetch_cnt_o  = fetch_cnt_q;

endmodule

// File: tb/tb_if_stage.sv
// tb/tb_if_stage.sv - directed and randomized bench for if_stage against a reference model
module tb_if_stage;

    localparam int          WORDS = 32;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        stall_i = 1'b0;
    logic        redirect_i = 1'b0;
    logic [31:0] redirect_target_i = 32'd0;
    logic [31:0] imem_addr_o, imem_instr_i, pc_o, ifid_pc_o, ifid_pc4_o, ifid_instr_o, fetch_cnt_o;
    logic        ifid_valid_o, halted_o, align_err_o;

    logic [31:0] mem [0:WORDS-1];

    int total = 0;
    int bad   = 0;

    logic [31:0] m_pc, m_ifid_pc, m_ifid_pc4, m_ifid_instr, m_cnt;
    logic        m_valid, m_align;

    if_stage #(.RESET_PC(32'h0), .IMEM_WORDS(WORDS), .NOP_INSTR(NOP)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .stall_i(stall_i), .redirect_i(redirect_i),
        .redirect_target_i(redirect_target_i), .imem_addr_o(imem_addr_o),
        .imem_instr_i(imem_instr_i), .pc_o(pc_o), .ifid_pc_o(ifid_pc_o),
        .ifid_pc4_o(ifid_pc4_o), .ifid_instr_o(ifid_instr_o), .ifid_valid_o(ifid_valid_o),
        .halted_o(halted_o), .align_err_o(align_err_o), .fetch_cnt_o(fetch_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    // Out-of-range reads return junk so any use of it in the IF/ID register shows up.
    assign imem_instr_i = (imem_addr_o < WORDS * 4) ? mem[imem_addr_o[6:2]] : ~imem_addr_o;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("pc", pc_o, m_pc);
        chk("imem_addr", imem_addr_o, m_pc);
        chk("halted", {31'd0, halted_o}, {31'd0, m_pc >= WORDS * 4});
        chk("ifid_pc", ifid_pc_o, m_ifid_pc);
        chk("ifid_pc4", ifid_pc4_o, m_ifid_pc4);
        chk("ifid_instr", ifid_instr_o, m_ifid_instr);
        chk("ifid_valid", {31'd0, ifid_valid_o}, {31'd0, m_valid});
        chk("align_err", {31'd0, align_err_o}, {31'd0, m_align});
        chk("fetch_cnt", fetch_cnt_o, m_cnt);
    endtask

    // One clock: drive inputs, advance the model by the rules, compare at the falling edge.
    task automatic step(input logic rst, input logic stall, input logic redir, input logic [31:0] tgt);
        logic [31:0] word;
        rst_i = rst; stall_i = stall; redirect_i = redir; redirect_target_i = tgt;
        word = (m_pc < WORDS * 4) ? mem[m_pc / 4] : 32'hx;
        @(posedge clk_i);
        if (rst) begin
            m_pc = 0; m_ifid_pc = 0; m_ifid_pc4 = 0; m_ifid_instr = NOP;
            m_valid = 0; m_align = 0; m_cnt = 0;
        end else if (redir) begin
            m_pc = tgt - (tgt % 4);
            m_ifid_instr = NOP; m_valid = 0;
            if (tgt % 4 != 0) m_align = 1;
        end else if (!stall) begin
            if (m_pc >= WORDS * 4) begin
                m_ifid_instr = NOP; m_valid = 0;
            end else begin
                m_ifid_pc = m_pc; m_ifid_pc4 = m_pc + 4; m_ifid_instr = word;
                m_valid = 1; m_cnt = m_cnt + 1; m_pc = m_pc + 4;
            end
        end
        @(negedge clk_i);
        check_all();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0);
    endtask

    initial begin
        for (int i = 0; i < WORDS; i++) mem[i] = 32'h1000_0000 + i;
        m_pc = 0; m_ifid_pc = 0; m_ifid_pc4 = 0; m_ifid_instr = NOP;
        m_valid = 0; m_align = 0; m_cnt = 0;

        step(1, 0, 0, 0);
        chk("reset_pc", pc_o, 32'h0);
        chk("reset_instr", ifid_instr_o, NOP);

        step(0, 0, 0, 0);
        chk("e1_instr", ifid_instr_o, 32'h1000_0000);
        step(0, 0, 0, 0);
        chk("e2_instr", ifid_instr_o, 32'h1000_0001);
        chk("e2_pc", pc_o, 32'h8);

        step(0, 1, 0, 0);
        step(0, 1, 0, 0);
        chk("stall_pc", pc_o, 32'h8);
        chk("stall_instr", ifid_instr_o, 32'h1000_0001);
        chk("stall_cnt", fetch_cnt_o, 32'd2);
        step(0, 0, 0, 0);
        chk("release_instr", ifid_instr_o, 32'h1000_0002);
        chk("release_ifid_pc", ifid_pc_o, 32'h8);
        chk("release_cnt", fetch_cnt_o, 32'd3);

        step(0, 1, 1, 32'h40);
        chk("redir_pc", pc_o, 32'h40);
        chk("redir_valid", {31'd0, ifid_valid_o}, 32'd0);
        chk("redir_instr", ifid_instr_o, NOP);
        step(0, 0, 0, 0);
        chk("post_redir_instr", ifid_instr_o, 32'h1000_0010);
        chk("post_redir_pc", ifid_pc_o, 32'h40);

        step(0, 0, 1, 32'h46);
        chk("misalign_pc", pc_o, 32'h44);
        chk("misalign_err", {31'd0, align_err_o}, 32'd1);
        step(0, 0, 1, 32'h0);
        chk("sticky_err", {31'd0, align_err_o}, 32'd1);

        step(1, 0, 0, 0);
        run(31);
        chk("last_pc", pc_o, 32'h7C);
        step(0, 0, 0, 0);
        chk("last_instr", ifid_instr_o, 32'h1000_001F);
        chk("last_halt", {31'd0, halted_o}, 32'd1);
        chk("last_cnt", fetch_cnt_o, 32'd32);
        run(2);
        chk("halt_pc", pc_o, 32'h80);
        chk("halt_valid", {31'd0, ifid_valid_o}, 32'd0);
        chk("halt_cnt", fetch_cnt_o, 32'd32);
        step(0, 0, 1, 32'h0);
        chk("unhalt", {31'd0, halted_o}, 32'd0);

        step(0, 0, 1, 32'h22);
        chk("pre_rst_pc", pc_o, 32'h20);
        step(0, 1, 0, 0);
        step(1, 1, 0, 0);
        chk("rst_stall_pc", pc_o, 32'h0);
        chk("rst_stall_cnt", fetch_cnt_o, 32'd0);
        chk("rst_stall_err", {31'd0, align_err_o}, 32'd0);
        step(1, 0, 1, 32'h33);
        chk("rst_redir_pc", pc_o, 32'h0);
        step(0, 0, 0, 0);
        chk("first_fetch", ifid_instr_o, 32'h1000_0000);
        chk("first_fetch_valid", {31'd0, ifid_valid_o}, 32'd1);

        for (int i = 0; i < WORDS; i++) mem[i] = $urandom;
        for (int n = 0; n < 600; n++) begin
            logic r, s, d;
            logic [31:0] t;
            r = ($urandom_range(0, 63) == 0);
            s = ($urandom_range(0, 3) == 0);
            d = ($urandom_range(0, 7) == 0);
            t = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 32'h9F));
            step(r, s, d, t);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
